// File: rtl/pc_sequencer_if.sv
// Command/status bundle between the control unit (master) and the PC sequencer (slave).
// Latency: n/a (wires only). Backpressure: none, commands are sampled every cycle.
// Stack status lines are present even when the sequencer is built without PC_STACK_EN.
interface pc_sequencer_if #(
    parameter int ADDR_W      = 12,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic              pc_load;
    logic              pc_call;
    logic              pc_ret;
    logic              pc_branch;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_address;
    logic [OFF_W-1:0]  pc_offset;
    logic [ADDR_W-1:0] pc_out;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output pc_load, pc_call, pc_ret, pc_branch, pc_inc, pc_address, pc_offset,
        input  pc_out, stack_level, stack_ovf, stack_unf
    );

    modport slave (
        input  pc_load, pc_call, pc_ret, pc_branch, pc_inc, pc_address, pc_offset,
        output pc_out, stack_level, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC: jump, signed relative branch, increment, optional call/return stack (PC_STACK_EN).
// Latency: 1 cycle, pc_out and stack status are registered.
// Backpressure: none; a refused call/ret holds the PC and pulses stack_ovf/stack_unf for one cycle.
module pc_sequencer #(
    parameter int              ADDR_W      = 12,
    parameter int              OFF_W       = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] off_sext;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign off_sext = ADDR_W'($signed(bus.pc_offset));
    assign br_tgt   = pc_q + off_sext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc_out = pc_q;

`ifdef PC_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              push;
    logic              ovf_d;
    logic              unf_d;
    logic              ovf_q;
    logic              unf_q;
    logic              stack_full;
    logic              stack_empty;

    assign stack_full  = (level_q == LVL_W'(STACK_DEPTH));
    assign stack_empty = (level_q == '0);
    assign push_idx    = IDX_W'(level_q);
    assign top_idx     = IDX_W'(level_q - LVL_W'(1));

    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        push    = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (bus.pc_load) begin
            pc_d = bus.pc_address;
        end else if (bus.pc_call) begin
            if (stack_full) begin
                ovf_d = 1'b1;
            end else begin
                push    = 1'b1;
                level_d = level_q + LVL_W'(1);
                pc_d    = bus.pc_address;
            end
        end else if (bus.pc_ret) begin
            if (stack_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_d    = stack_mem[top_idx];
                level_d = level_q - LVL_W'(1);
            end
        end else if (bus.pc_branch) begin
            pc_d = br_tgt;
        end else if (bus.pc_inc) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are never cleared; level_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

    assign bus.stack_level = level_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
`else
    logic unused_ret;
    assign unused_ret = bus.pc_ret;

    // Without a stack a call is just a jump; ret drops through to branch/inc.
    always_comb begin
        pc_d = pc_q;
        if (bus.pc_load || bus.pc_call) begin
            pc_d = bus.pc_address;
        end else if (bus.pc_branch) begin
            pc_d = br_tgt;
        end else if (bus.pc_inc) begin
            pc_d = pc_plus1;
        end
    end

    assign bus.stack_level = LVL_W'(0);
    assign bus.stack_ovf   = 1'b0;
    assign bus.stack_unf   = 1'b0;
`endif
endmodule
